fix_trailer_ctrl: RTL and testbench

Sequencer that owns the FIX checksum datapath on the transmit side. It forwards a message body byte-stream unchanged and accumulates the mod-256 byte sum of every accepted byte. After the last body byte it suspends the input and appends the 7-byte trailer "10=DDD<SOH>", where DDD is the three-digit ASCII decimal checksum. It sits between the message builder and the byte serializer.

---
 rtl/fix_pkg.sv | 19 +
 rtl/cks_bin2dec.sv | 31 +++
 rtl/fix_trailer_ctrl.sv | 130 +++++++++++++
 tb/tb_fix_trailer_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared constants and state type for the FIX checksum trailer datapath.
// Used by the transmit sequencer and the binary-to-decimal digit converter.
package fix_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] TAG_1       = 8'h31;
    localparam logic [7:0] TAG_0       = 8'h30;
    localparam logic [7:0] TAG_EQ      = 8'h3D;
    localparam logic [7:0] SOH_DEFAULT = 8'h01;

    localparam int TRAILER_LEN = 7;
    localparam logic [2:0] IDX_LAST = 3'(TRAILER_LEN - 1);

    typedef enum logic {
        BODY,
        TRAILER
    } state_e;

endpackage

// File: rtl/cks_bin2dec.sv
// Combinational 8-bit binary to three ASCII decimal digits.
// Ports: bin_i (0..255) -> hund_o, tens_o, units_o as ASCII '0'..'9'.
module cks_bin2dec
    import fix_pkg::*;
(
    input  logic [7:0] bin_i,
    output logic [7:0] hund_o,
    output logic [7:0] tens_o,
    output logic [7:0] units_o
);

    logic [1:0] hund;
    logic [7:0] rem;

    // Hundreds digit is at most 2, so two compares replace a divider.
    always_comb begin
        hund = 2'd0;
        rem  = bin_i;
        if (bin_i >= 8'd200) begin
            hund = 2'd2;
            rem  = bin_i - 8'd200;
        end else if (bin_i >= 8'd100) begin
            hund = 2'd1;
            rem  = bin_i - 8'd100;
        end
        hund_o  = ASCII_ZERO + {6'd0, hund};
        tens_o  = ASCII_ZERO + (rem / 8'd10);
        units_o = ASCII_ZERO + (rem % 8'd10);
    end

endmodule

// File: rtl/fix_trailer_ctrl.sv
// FIX transmit trailer sequencer: forwards body bytes, sums them mod 256,
// then appends "10=DDD<SOH>". Ports: s_* upstream body stream, m_* downstream
// stream, cks_o/cks_valid last checksum with update pulse, busy in trailer.
module fix_trailer_ctrl
    import fix_pkg::*;
#(
    parameter logic [7:0] SEED = 8'd0,
    parameter logic [7:0] SOH  = SOH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       m_ready,
    output logic [7:0] cks_o,
    output logic       cks_valid,
    output logic       busy
);

    state_e     state_q;
    logic [7:0] acc_q;
    logic [7:0] sum_q;
    logic [7:0] cks_q;
    logic [2:0] idx_q;
    logic       cks_valid_q;

    logic [7:0] sum_d;
    logic       accept;
    logic [7:0] dig_h;
    logic [7:0] dig_t;
    logic [7:0] dig_u;
    logic [7:0] tr_byte;

    cks_bin2dec u_b2d (
        .bin_i   (sum_q),
        .hund_o  (dig_h),
        .tens_o  (dig_t),
        .units_o (dig_u)
    );

    always_comb begin
        tr_byte = SOH;
        unique case (idx_q)
            3'd0:    tr_byte = TAG_1;
            3'd1:    tr_byte = TAG_0;
            3'd2:    tr_byte = TAG_EQ;
            3'd3:    tr_byte = dig_h;
            3'd4:    tr_byte = dig_t;
            3'd5:    tr_byte = dig_u;
            default: tr_byte = SOH;
        endcase
    end

    // Handshake outputs are forced low while reset is held so nothing
    // downstream sees a byte from a half-reset block.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = s_data;
        m_last  = 1'b0;
        busy    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                BODY: begin
                    m_valid = s_valid;
                    s_ready = m_ready;
                end
                TRAILER: begin
                    m_valid = 1'b1;
                    busy    = 1'b1;
                    m_data  = tr_byte;
                    m_last  = (idx_q == IDX_LAST);
                end
                default: ;
            endcase
        end
    end

    assign accept = s_valid & s_ready;
    assign sum_d  = acc_q + s_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BODY;
            acc_q       <= SEED;
            sum_q       <= 8'd0;
            cks_q       <= 8'd0;
            idx_q       <= 3'd0;
            cks_valid_q <= 1'b0;
        end else begin
            cks_valid_q <= 1'b0;
            unique case (state_q)
                BODY: begin
                    if (accept) begin
                        if (s_last) begin
                            sum_q       <= sum_d;
                            cks_q       <= sum_d;
                            cks_valid_q <= 1'b1;
                            acc_q       <= SEED;
                            idx_q       <= 3'd0;
                            state_q     <= TRAILER;
                        end else begin
                            acc_q <= sum_d;
                        end
                    end
                end
                TRAILER: begin
                    if (m_ready) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= 3'd0;
                            state_q <= BODY;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= BODY;
            endcase
        end
    end

    assign cks_o     = cks_q;
    assign cks_valid = cks_valid_q;

endmodule

// File: tb/tb_fix_trailer_ctrl.sv
// Scoreboard bench for fix_trailer_ctrl: stimulus pushes expected bytes,
// independent monitors pop and compare whenever the DUT presents output.
module tb_fix_trailer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready = 1'b1;
    logic [7:0] cks_o;
    logic       cks_valid;
    logic       busy;

    logic       s2_valid = 1'b0;
    logic [7:0] s2_data = 8'h00;
    logic       s2_last = 1'b0;
    logic       s2_ready;
    logic       m2_valid;
    logic [7:0] m2_data;
    logic       m2_last;
    logic       m2_ready = 1'b1;
    logic [7:0] cks2_o;
    logic       cks2_valid;
    logic       busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int soh_cyc = -100;
    int acc_cyc = 0;
    int soh_at_acc = 0;
    bit bp_en = 1'b0;
    bit stall_v = 1'b0;
    logic [8:0] stall_x = '0;

    logic [8:0] exp_q[$];
    logic [7:0] cks_exp_q[$];
    logic [8:0] exp2_q[$];
    logic [7:0] cks2_exp_q[$];
    logic [7:0] msg[8];

    fix_trailer_ctrl #(.SEED(8'd0), .SOH(8'h01)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready),
        .cks_o(cks_o), .cks_valid(cks_valid), .busy(busy)
    );

    fix_trailer_ctrl #(.SEED(8'h75), .SOH(8'h01)) dut_seed (
        .clk(clk), .rst(rst),
        .s_valid(s2_valid), .s_data(s2_data), .s_last(s2_last),
        .s_ready(s2_ready),
        .m_valid(m2_valid), .m_data(m2_data), .m_last(m2_last),
        .m_ready(m2_ready),
        .cks_o(cks2_o), .cks_valid(cks2_valid), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) m_ready = 1'($urandom_range(0, 1));
            else       m_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (busy) chk("s_ready_in_trailer", 32'(s_ready), 32'd0);
            if (stall_v && m_valid)
                chk("stall_stable", 32'({m_last, m_data}), 32'(stall_x));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'({m_last, m_data}), 32'h1ff);
                end else begin
                    chk("out_byte", 32'({m_last, m_data}),
                        32'(exp_q.pop_front()));
                end
                if (m_last) soh_cyc = cyc;
            end
            stall_v = m_valid && !m_ready;
            stall_x = {m_last, m_data};
            if (cks_valid) begin
                if (cks_exp_q.size() == 0)
                    chk("unexpected_cks", 32'(cks_o), 32'h1ff);
                else
                    chk("cks_o", 32'(cks_o), 32'(cks_exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m2_valid && m2_ready) begin
                if (exp2_q.size() == 0)
                    chk("seed_unexpected", 32'({m2_last, m2_data}), 32'h1ff);
                else
                    chk("seed_byte", 32'({m2_last, m2_data}),
                        32'(exp2_q.pop_front()));
            end
            if (cks2_valid) begin
                if (cks2_exp_q.size() == 0)
                    chk("seed_unexpected_cks", 32'(cks2_o), 32'h1ff);
                else
                    chk("seed_cks", 32'(cks2_o),
                        32'(cks2_exp_q.pop_front()));
            end
        end
    end

    task automatic push_trailer(input logic [7:0] d2, input logic [7:0] d1,
                                input logic [7:0] d0, input int nbytes);
        logic [8:0] tr[7];
        tr = '{9'h031, 9'h030, 9'h03D, {1'b0, d2}, {1'b0, d1},
               {1'b0, d0}, 9'h101};
        for (int k = 0; k < nbytes; k++) exp_q.push_back(tr[k]);
    endtask

    task automatic send_msg(input int n, input logic [7:0] d2,
                            input logic [7:0] d1, input logic [7:0] d0,
                            input logic [7:0] cks, input int trl,
                            input bit keep_valid);
        int t;
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, msg[i]});
        push_trailer(d2, d1, d0, trl);
        cks_exp_q.push_back(cks);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!s_ready && t < 200);
            if (t >= 200) chk("accept_timeout", 32'd0, 32'd1);
            if (i == 0) begin
                acc_cyc    = cyc;
                soh_at_acc = soh_cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!keep_valid) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        s_valid = 1'b1;
        s_data  = 8'h55;
        #2;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cks_o", 32'(cks_o), 32'd0);
        chk("rst_cks_valid", 32'(cks_valid), 32'd0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        msg = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h00, 8'h00, 8'h00};
        send_msg(5, 8'h30, 8'h39, 8'h32, 8'h5C, 7, 1'b0);
        wait_idle();
        chk("cks_hold", 32'(cks_o), 32'h5C);

        msg[0] = 8'hFF;
        send_msg(1, 8'h32, 8'h35, 8'h35, 8'hFF, 7, 1'b0);
        wait_idle();

        msg[0] = 8'h80;
        msg[1] = 8'h80;
        send_msg(2, 8'h30, 8'h30, 8'h30, 8'h00, 7, 1'b0);
        wait_idle();

        msg[0] = 8'h64;
        send_msg(1, 8'h31, 8'h30, 8'h30, 8'h64, 7, 1'b0);
        wait_idle();

        bp_en = 1'b1;
        msg = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h00, 8'h00, 8'h00};
        send_msg(5, 8'h30, 8'h39, 8'h32, 8'h5C, 7, 1'b0);
        wait_idle();
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        send_msg(5, 8'h30, 8'h39, 8'h32, 8'h5C, 7, 1'b1);
        msg[0] = 8'h64;
        send_msg(1, 8'h31, 8'h30, 8'h30, 8'h64, 7, 1'b0);
        chk("b2b_accept_gap", 32'(acc_cyc - soh_at_acc), 32'd1);
        wait_idle();

        msg = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h00, 8'h00, 8'h00};
        send_msg(5, 8'h30, 8'h39, 8'h32, 8'h5C, 5, 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(busy && m_data == 8'h39) && t < 100);
        if (t >= 100) chk("idx4_timeout", 32'd0, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_s_ready", 32'(s_ready), 32'd1);
        chk("postrst_cks_o", 32'(cks_o), 32'd0);
        chk("postrst_q_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        msg[0] = 8'h41;
        send_msg(1, 8'h30, 8'h36, 8'h35, 8'h41, 7, 1'b0);
        wait_idle();

        exp2_q = '{9'h046, 9'h049, 9'h058, 9'h031, 9'h030, 9'h03D,
                   9'h030, 9'h039, 9'h032, 9'h101};
        cks2_exp_q.push_back(8'h5C);
        msg = '{8'h46, 8'h49, 8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            s2_valid = 1'b1;
            s2_data  = msg[i];
            s2_last  = (i == 2);
            @(posedge clk);
            #1;
        end
        s2_valid = 1'b0;
        s2_last  = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("seed_q_empty", 32'(exp2_q.size()), 32'd0);
        chk("seed_cks_q_empty", 32'(cks2_exp_q.size()), 32'd0);
        chk("cks_q_empty", 32'(cks_exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1, "timeout");
    end

endmodule
